alu_pipe: RTL and testbench

Parametrised, pipelined ALU core that succeeds the single-cycle ALU in the verification environment. It adds configurable data width, configurable pipeline depth, a pass-through transaction tag, result flags, and a valid/ready handshake with output backpressure. It sits between the instruction-issue driver (operand/opcode source) and the result monitor/scoreboard.

---
 rtl/alu_pipe.sv | 171 +++++++++++++++++
 tb/tb_alu_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined ALU with valid/ready handshake, global stall and a pass-through tag.
// Define ALU_MULT_EN to make OP 15 a multiply; otherwise OP 15 reports an error result.
module alu_pipe #(
    parameter int DATA_WIDTH  = 8,
    parameter int PIPE_STAGES = 3,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ACT,
    output logic                  ALU_RDY,
    input  logic [3:0]            OP,
    input  logic [1:0]            MOVI,
    input  logic [DATA_WIDTH-1:0] REG_A,
    input  logic [DATA_WIDTH-1:0] REG_B,
    input  logic [DATA_WIDTH-1:0] MEM,
    input  logic [DATA_WIDTH-1:0] IMM,
    input  logic [TAG_WIDTH-1:0]  TAG,
    input  logic                  DST_RDY,
    output logic [DATA_WIDTH-1:0] EX_ALU,
    output logic                  EX_ALU_VLD,
    output logic [TAG_WIDTH-1:0]  EX_TAG,
    output logic                  EX_CARRY,
    output logic                  EX_ZERO,
    output logic                  EX_ERR
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_INC  = 4'd2,  OP_DEC  = 4'd3,
        OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR  = 4'd6,  OP_NOT  = 4'd7,
        OP_SHL  = 4'd8,  OP_SHR  = 4'd9,  OP_ROL  = 4'd10, OP_ROR  = 4'd11,
        OP_NAND = 4'd12, OP_NOR  = 4'd13, OP_XNOR = 4'd14, OP_MUL  = 4'd15
    } op_e;

    typedef struct packed {
        logic                  vld;
        logic [DATA_WIDTH-1:0] res;
        logic                  carry;
        logic                  zero;
        logic                  err;
        logic [TAG_WIDTH-1:0]  tag;
    } stage_t;

    localparam int W = DATA_WIDTH;

    stage_t          pipe [PIPE_STAGES];
    stage_t          stage_in;
    logic            advance;
    logic            accept;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            bad_b;
    logic [W-1:0]    res;
    logic            carry;
    logic            err;
    logic [W:0]      ext;
`ifdef ALU_MULT_EN
    logic [2*W-1:0]  prod;
`endif

    // Global stall: the whole pipe moves only when the output slot is free or being consumed.
    assign advance = !pipe[PIPE_STAGES-1].vld || DST_RDY;
    assign ALU_RDY = advance && !RST;
    assign accept  = ACT && ALU_RDY;
    assign a       = REG_A;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        b     = '0;
        bad_b = 1'b0;
        case (MOVI)
            2'b00:   b = REG_B;
            2'b01:   b = MEM;
            2'b10:   b = IMM;
            default: bad_b = 1'b1;
        endcase
    end

    always_comb begin
        res   = '0;
        carry = 1'b0;
        err   = bad_b;
        ext   = '0;
`ifdef ALU_MULT_EN
        prod  = '0;
`endif
        case (op_e'(OP))
            OP_ADD: begin
                ext   = {1'b0, a} + {1'b0, b};
                res   = ext[W-1:0];
                carry = ext[W];
            end
            OP_SUB: begin
                ext   = {1'b0, a} - {1'b0, b};
                res   = ext[W-1:0];
                carry = ext[W];
            end
            OP_INC: begin
                ext   = {1'b0, a} + (W+1)'(1);
                res   = ext[W-1:0];
                carry = ext[W];
            end
            OP_DEC: begin
                ext   = {1'b0, a} - (W+1)'(1);
                res   = ext[W-1:0];
                carry = ext[W];
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOT:  res = ~a;
            OP_SHL: begin
                res   = {a[W-2:0], 1'b0};
                carry = a[W-1];
            end
            OP_SHR: begin
                res   = {1'b0, a[W-1:1]};
                carry = a[0];
            end
            OP_ROL: begin
                res   = {a[W-2:0], a[W-1]};
                carry = a[W-1];
            end
            OP_ROR: begin
                res   = {a[0], a[W-1:1]};
                carry = a[0];
            end
            OP_NAND: res = ~(a & b);
            OP_NOR:  res = ~(a | b);
            OP_XNOR: res = ~(a ^ b);
            OP_MUL: begin
`ifdef ALU_MULT_EN
                prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                res   = prod[W-1:0];
                carry = |prod[2*W-1:W];
`else
                err   = 1'b1;
`endif
            end
        endcase
    end

    always_comb begin
        stage_in       = '0;
        stage_in.vld   = accept;
        stage_in.res   = res;
        stage_in.carry = carry;
        stage_in.zero  = (res == '0);
        stage_in.err   = err;
        stage_in.tag   = TAG;
    end

    // NOTE: state updates use non-blocking assignments so every stage samples its predecessor's old value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: all stages, data included, are cleared so nothing from before reset can resurface.
            for (int i = 0; i < PIPE_STAGES; i++) pipe[i] <= '0;
        end else if (advance) begin
            pipe[0] <= stage_in;
            for (int i = 1; i < PIPE_STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign EX_ALU_VLD = pipe[PIPE_STAGES-1].vld;
    assign EX_ALU     = pipe[PIPE_STAGES-1].res;
    assign EX_TAG     = pipe[PIPE_STAGES-1].tag;
    assign EX_CARRY   = pipe[PIPE_STAGES-1].carry;
    assign EX_ZERO    = pipe[PIPE_STAGES-1].zero;
    assign EX_ERR     = pipe[PIPE_STAGES-1].err;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe (8-bit, 3 stages) against an
// arithmetic reference model and an in-order scoreboard. Honors ALU_MULT_EN like the design.
module tb_alu_pipe;

    localparam int DW   = 8;
    localparam int TW   = 4;
    localparam int MASK = (1 << DW) - 1;

    typedef struct {
        int res;
        int c;
        int z;
        int e;
        int tg;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ACT;
    logic          ALU_RDY;
    logic [3:0]    OP;
    logic [1:0]    MOVI;
    logic [DW-1:0] REG_A, REG_B, MEM, IMM;
    logic [TW-1:0] TAG;
    logic          DST_RDY;
    logic [DW-1:0] EX_ALU;
    logic          EX_ALU_VLD;
    logic [TW-1:0] EX_TAG;
    logic          EX_CARRY, EX_ZERO, EX_ERR;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    bit   accepted;
    bit   rand_rdy = 0;
    exp_t sbq[$];

    alu_pipe #(.DATA_WIDTH(DW), .PIPE_STAGES(3), .TAG_WIDTH(TW)) dut (
        .CLK(CLK), .RST(RST), .ACT(ACT), .ALU_RDY(ALU_RDY),
        .OP(OP), .MOVI(MOVI), .REG_A(REG_A), .REG_B(REG_B), .MEM(MEM), .IMM(IMM),
        .TAG(TAG), .DST_RDY(DST_RDY),
        .EX_ALU(EX_ALU), .EX_ALU_VLD(EX_ALU_VLD), .EX_TAG(EX_TAG),
        .EX_CARRY(EX_CARRY), .EX_ZERO(EX_ZERO), .EX_ERR(EX_ERR)
    );

    always #5 CLK = ~CLK;

    // Reference model: plain integer arithmetic, then reduced modulo 2^DW.
    function automatic exp_t model(int op, int movi, int a, int rb, int m, int im, int tg);
        exp_t x;
        int   b;
        int   r;
        x.c = 0;
        x.e = (movi == 3) ? 1 : 0;
        b   = (movi == 0) ? rb : (movi == 1) ? m : (movi == 2) ? im : 0;
        r   = 0;
        case (op)
            0:  begin r = a + b; x.c = (r > MASK) ? 1 : 0; end
            1:  begin r = a - b; x.c = (a < b) ? 1 : 0; end
            2:  begin r = a + 1; x.c = (r > MASK) ? 1 : 0; end
            3:  begin r = a - 1; x.c = (a < 1) ? 1 : 0; end
            4:  r = a & b;
            5:  r = a | b;
            6:  r = a ^ b;
            7:  r = ~a;
            8:  begin r = a * 2; x.c = a / (1 << (DW-1)); end
            9:  begin r = a / 2; x.c = a % 2; end
            10: begin r = a * 2 + a / (1 << (DW-1)); x.c = a / (1 << (DW-1)); end
            11: begin r = a / 2 + (a % 2) * (1 << (DW-1)); x.c = a % 2; end
            12: r = ~(a & b);
            13: r = ~(a | b);
            14: r = ~(a ^ b);
            default: begin
`ifdef ALU_MULT_EN
                r   = a * b;
                x.c = (r > MASK) ? 1 : 0;
`else
                r   = 0;
                x.e = 1;
`endif
            end
        endcase
        x.res = r & MASK;
        x.z   = (x.res == 0) ? 1 : 0;
        x.tg  = tg;
        return x;
    endfunction

    task automatic check(string name, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Negedge sampling: score the consumed result, then record an accepted transaction.
    task automatic neg();
        exp_t x;
        @(negedge CLK);
        accepted = ACT && ALU_RDY;
        if (EX_ALU_VLD && DST_RDY) begin
            if (sbq.size() == 0) begin
                check("stale_result", 32'(EX_ALU_VLD), 0);
            end else begin
                x = sbq.pop_front();
                n_out++;
                check("sb_res",   32'(EX_ALU),   x.res);
                check("sb_carry", 32'(EX_CARRY), x.c);
                check("sb_zero",  32'(EX_ZERO),  x.z);
                check("sb_err",   32'(EX_ERR),   x.e);
                check("sb_tag",   32'(EX_TAG),   x.tg);
            end
        end
        if (RST) sbq.delete();
        else if (accepted)
            sbq.push_back(model(int'(OP), int'(MOVI), int'(REG_A), int'(REG_B),
                                int'(MEM), int'(IMM), int'(TAG)));
    endtask

    task automatic pos();
        @(posedge CLK);
        #1;
        if (rand_rdy) DST_RDY = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive(int op, int movi, int a, int rb, int m, int im, int tg);
        OP    = 4'(op);
        MOVI  = 2'(movi);
        REG_A = DW'(a);
        REG_B = DW'(rb);
        MEM   = DW'(m);
        IMM   = DW'(im);
        TAG   = TW'(tg);
        ACT   = 1'b1;
    endtask

    task automatic wait_accept(string name);
        bit got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            neg();
            got = accepted;
            pos();
        end
        if (!got) check(name, 32'(accepted), 1);
    endtask

    task automatic expect_result(string name, int res, int c, int z, int e, int tg);
        bit got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            neg();
            if (EX_ALU_VLD) begin
                got = 1;
                check({name, "_res"},   32'(EX_ALU),   res);
                check({name, "_carry"}, 32'(EX_CARRY), c);
                check({name, "_zero"},  32'(EX_ZERO),  z);
                check({name, "_err"},   32'(EX_ERR),   e);
                check({name, "_tag"},   32'(EX_TAG),   tg);
            end
            pos();
        end
        if (!got) check({name, "_timeout"}, 32'(EX_ALU_VLD), 1);
    endtask

    task automatic drain();
        DST_RDY = 1'b1;
        for (int k = 0; k < 50 && sbq.size() != 0; k++) begin
            neg();
            pos();
        end
        check("drain_empty", 32'(sbq.size()), 0);
    endtask

    initial begin
        int n0;
        RST = 1'b1; ACT = 1'b0; DST_RDY = 1'b0;
        OP = '0; MOVI = '0; REG_A = '0; REG_B = '0; MEM = '0; IMM = '0; TAG = '0;

        // Reset state
        pos(); pos();
        neg();
        check("rst_vld",   32'(EX_ALU_VLD), 0);
        check("rst_alu",   32'(EX_ALU),     0);
        check("rst_tag",   32'(EX_TAG),     0);
        check("rst_flags", 32'({EX_CARRY, EX_ZERO, EX_ERR}), 0);
        check("rst_rdy",   32'(ALU_RDY),    0);
        pos();
        RST = 1'b0; DST_RDY = 1'b1;
        neg();
        check("rdy_after_rst", 32'(ALU_RDY), 1);
        pos();

        // ADD with carry-out and latency measurement
        drive(0, 0, 8'hFF, 8'h01, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 5);
        neg(); check("add_accept", 32'(accepted), 1); pos();
        ACT = 1'b0;
        neg(); check("add_lat_e1", 32'(EX_ALU_VLD), 0); pos();
        neg(); check("add_lat_e2", 32'(EX_ALU_VLD), 0); pos();
        neg();
        check("add_lat_vld", 32'(EX_ALU_VLD), 1);
        check("add_res",     32'(EX_ALU),     8'h00);
        check("add_carry",   32'(EX_CARRY),   1);
        check("add_zero",    32'(EX_ZERO),    1);
        check("add_err",     32'(EX_ERR),     0);
        check("add_tag",     32'(EX_TAG),     5);
        pos();

        // SUB from MEM with borrow
        drive(1, 1, 8'h10, int'($urandom_range(0, 255)), 8'h20, int'($urandom_range(0, 255)), 1);
        wait_accept("sub_accept"); ACT = 1'b0;
        expect_result("sub", 8'hF0, 1, 0, 0, 1);

        // ROL
        drive(10, 0, 8'h81, 0, 0, 0, 2);
        wait_accept("rol_accept"); ACT = 1'b0;
        expect_result("rol", 8'h03, 1, 0, 0, 2);

        // Illegal operand-B select: B forced to 0, error flagged
        drive(0, 3, 8'h12, 8'h34, 8'h56, 8'h78, 3);
        wait_accept("movi_accept"); ACT = 1'b0;
        expect_result("movi11", 8'h12, 0, 0, 1, 3);

        // OP 15
        drive(15, 0, 8'h10, 8'h10, 0, 0, 4);
        wait_accept("mul_accept"); ACT = 1'b0;
`ifdef ALU_MULT_EN
        expect_result("mul", 8'h00, 1, 1, 0, 4);
`else
        expect_result("mul_off", 8'h00, 0, 1, 1, 4);
`endif

        // Back-to-back with 5 cycles of backpressure
        n0 = n_out;
        for (int t = 0; t < 3; t++) begin
            drive(0, 0, 8'h10 + t, 8'h01, 0, 0, t);
            wait_accept("bp_accept");
        end
        drive(0, 0, 8'h13, 8'h01, 0, 0, 3);
        DST_RDY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            neg();
            check("bp_vld",   32'(EX_ALU_VLD), 1);
            check("bp_rdy",   32'(ALU_RDY),    0);
            check("bp_hold",  32'(EX_ALU),     8'h11);
            check("bp_tag",   32'(EX_TAG),     0);
            pos();
        end
        DST_RDY = 1'b1;
        wait_accept("bp_accept3");
        ACT = 1'b0;
        drain();
        check("bp_count", 32'(n_out - n0), 4);

        // Reset with transactions in flight
        for (int t = 7; t < 10; t++) begin
            drive(5, 2, int'($urandom_range(1, 255)), 0, 0, int'($urandom_range(0, 255)), t);
            wait_accept("mrst_accept");
        end
        ACT = 1'b0; RST = 1'b1; DST_RDY = 1'b0;
        neg(); check("mrst_rdy_in_rst", 32'(ALU_RDY), 0); pos();
        RST = 1'b0; DST_RDY = 1'b1;
        neg();
        check("mrst_vld",   32'(EX_ALU_VLD), 0);
        check("mrst_alu",   32'(EX_ALU),     0);
        check("mrst_tag",   32'(EX_TAG),     0);
        check("mrst_flags", 32'({EX_CARRY, EX_ZERO, EX_ERR}), 0);
        check("mrst_rdy",   32'(ALU_RDY),    1);
        pos();
        for (int k = 0; k < 6; k++) begin
            neg(); check("mrst_no_stale", 32'(EX_ALU_VLD), 0); pos();
        end

        // Random stream with random backpressure
        n0 = n_out;
        rand_rdy = 1;
        for (int k = 0; k < 1000; k++) begin
            drive(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 15)));
            wait_accept("rnd_accept");
        end
        ACT = 1'b0;
        rand_rdy = 0;
        drain();
        check("rnd_count", 32'(n_out - n0), 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
